alu_operand_sequencer: RTL



---
 rtl/alu_operand_sequencer.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_operand_sequencer.sv
// Multi-cycle control sequencer for an 8-bit A/B register + ALU datapath.
// Accepts one instruction at a time and drives registered mux/ALU/load controls.
module alu_operand_sequencer #(
    parameter int DW  = 8,
    parameter int OPW = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [OPW-1:0] opcode,
    input  logic [DW-1:0]  imm,
    input  logic           dest,
    output logic [1:0]     sel_b,
    output logic [DW-1:0]  im_out,
    output logic [2:0]     alu_op,
    output logic           load_a,
    output logic           load_b,
    output logic           busy,
    output logic           done,
    output logic           illegal
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] sel_b;
        logic [2:0] alu_op;
        logic       load_a;
        logic       load_b;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{sel_b: 2'b00, alu_op: 3'b000, load_a: 1'b0, load_b: 1'b0};

    // Control word for one EXEC step of a legal opcode; SWAP is A+=B, B=A-B, A-=B.
    function automatic ctrl_t decode(input logic [2:0] op, input logic dst, input logic [1:0] step);
        ctrl_t c;
        c = CTRL_IDLE;
        case (op)
            3'd0: begin c.alu_op = 3'b000; c.load_a = ~dst; c.load_b = dst; end
            3'd1: begin c.alu_op = 3'b001; c.load_a = ~dst; c.load_b = dst; end
            3'd2: begin c.sel_b = 2'b01; c.alu_op = 3'b000; c.load_a = ~dst; c.load_b = dst; end
            3'd3: begin c.sel_b = 2'b01; c.alu_op = 3'b001; c.load_a = ~dst; c.load_b = dst; end
            3'd4: begin c.alu_op = 3'b010; c.load_a = ~dst; c.load_b = dst; end
            3'd5: begin c.sel_b = 2'b01; c.alu_op = 3'b010; c.load_a = ~dst; c.load_b = dst; end
            3'd6: begin c.sel_b = 2'b10; c.alu_op = 3'b010; c.load_a = ~dst; c.load_b = dst; end
            3'd7: begin
                case (step)
                    2'd0:    begin c.alu_op = 3'b000; c.load_a = 1'b1; end
                    2'd1:    begin c.alu_op = 3'b001; c.load_b = 1'b1; end
                    2'd2:    begin c.alu_op = 3'b001; c.load_a = 1'b1; end
                    default: c = CTRL_IDLE;
                endcase
            end
            default: c = CTRL_IDLE;
        endcase
        return c;
    endfunction

    state_t         r_state;
    logic [1:0]     r_step;
    logic [2:0]     r_op;
    logic           r_dest;
    logic [DW-1:0]  r_im;
    ctrl_t          r_ctrl;
    logic           r_ready;
    logic           r_busy;
    logic           r_done;
    logic           r_illegal;

    logic           w_illegal_op;
    logic [1:0]     w_next_step;
    logic           w_last_step;
    ctrl_t          w_first_ctrl;
    ctrl_t          w_next_ctrl;

    assign w_illegal_op = |opcode[OPW-1:3];
    assign w_next_step  = r_step + 2'd1;
    assign w_last_step  = (r_op == 3'd7) ? (r_step == 2'd2) : 1'b1;
    assign w_first_ctrl = decode(opcode[2:0], dest, 2'd0);
    assign w_next_ctrl  = decode(r_op, r_dest, w_next_step);

    // Sequencer FSM; every output is registered together with the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_step    <= 2'd0;
            r_op      <= 3'd0;
            r_dest    <= 1'b0;
            r_im      <= '0;
            r_ctrl    <= CTRL_IDLE;
            r_ready   <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (instr_valid) begin
                        r_op    <= opcode[2:0];
                        r_dest  <= dest;
                        r_im    <= imm;
                        r_step  <= 2'd0;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        if (w_illegal_op) begin
                            r_state   <= ST_DONE;
                            r_done    <= 1'b1;
                            r_illegal <= 1'b1;
                            r_ctrl    <= CTRL_IDLE;
                        end else begin
                            r_state <= ST_EXEC;
                            r_ctrl  <= w_first_ctrl;
                        end
                    end else begin
                        r_ctrl <= CTRL_IDLE;
                    end
                end
                ST_EXEC: begin
                    if (w_last_step) begin
                        r_state <= ST_DONE;
                        r_ctrl  <= CTRL_IDLE;
                        r_done  <= 1'b1;
                    end else begin
                        r_step <= w_next_step;
                        r_ctrl <= w_next_ctrl;
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    r_ctrl    <= CTRL_IDLE;
                    r_done    <= 1'b0;
                    r_illegal <= 1'b0;
                    r_busy    <= 1'b0;
                    r_ready   <= 1'b1;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    r_ctrl    <= CTRL_IDLE;
                    r_done    <= 1'b0;
                    r_illegal <= 1'b0;
                    r_busy    <= 1'b0;
                    r_ready   <= 1'b1;
                end
            endcase
        end
    end

    assign instr_ready = r_ready;
    assign sel_b       = r_ctrl.sel_b;
    assign alu_op      = r_ctrl.alu_op;
    assign load_a      = r_ctrl.load_a;
    assign load_b      = r_ctrl.load_b;
    assign im_out      = r_im;
    assign busy        = r_busy;
    assign done        = r_done;
    assign illegal     = r_illegal;

endmodule
